// File: rtl/uart_frame_rx.sv
// uart_frame_rx
// Validates framed byte traffic arriving from a UART RX bridge and forwards
// only the payload of frames whose checksum matches.
//
// Frame on the wire: SOF, LEN, LEN payload bytes, CHK,
// where CHK = XOR of LEN and every payload byte.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   s_tdata    incoming byte                (DATA_WIDTH)
//   s_tvalid   incoming byte valid
//   s_tready   block can take a byte (low only while draining a frame)
//   m_tdata    validated payload byte       (DATA_WIDTH)
//   m_tvalid   payload byte valid
//   m_tready   downstream can take a byte
//   m_tlast    marks the final payload byte of a frame
//   frame_ok   one-cycle pulse when a frame passes its checksum
//   frame_err  one-cycle pulse on bad length, bad checksum or timeout
//   err_count  saturating count of frame_err pulses
module uart_frame_rx #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    MAX_LEN    = 16,
    parameter logic [DATA_WIDTH-1:0] SOF        = DATA_WIDTH'(8'hA5),
    parameter int                    TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  frame_ok,
    output logic                  frame_err,
    output logic [7:0]            err_count
);

    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [DATA_WIDTH-1:0] MAX_LEN_W = DATA_WIDTH'(MAX_LEN);
    localparam logic [CW-1:0]         TIMEOUT_W = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        PAYLOAD,
        CHK,
        DRAIN
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   buffer [MAX_LEN];
    logic [IW-1:0]           wr_idx;
    logic [IW-1:0]           rd_idx;
    logic [IW-1:0]           last_idx;
    logic [DATA_WIDTH-1:0]   chk;
    logic [CW-1:0]           idle_cnt;

    logic                    accept;
    logic                    in_frame;
    logic                    timeout_hit;
    logic [IW-1:0]           rd_next;
    logic [7:0]              err_next;

    // Input side is only ever blocked while a validated frame is being
    // drained, so the buffer can never be overwritten mid-drain.
    // The timeout check compares against the count reached so far, which
    // means a byte presented on the timeout cycle itself is dropped rather
    // than folded into the abandoned frame.
    always_comb begin
        s_tready    = (state != DRAIN);
        accept      = s_tvalid && s_tready;
        in_frame    = (state == LEN) || (state == PAYLOAD) || (state == CHK);
        timeout_hit = (TIMEOUT != 0) && in_frame && (idle_cnt == TIMEOUT_W);
        rd_next     = rd_idx + 1'b1;
        err_next    = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
    end

    // Payload storage has no reset: a frame only reaches DRAIN after every
    // slot up to LEN-1 has been rewritten, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (state == PAYLOAD && accept && !timeout_hit) begin
            buffer[wr_idx] <= s_tdata;
        end
    end

    // Frame parser and output sequencer. The first output beat is loaded
    // in the same edge that accepts a matching checksum, so m_tvalid rises
    // the very next cycle. During DRAIN the output registers only move on a
    // handshake, which keeps them stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_idx    <= '0;
            rd_idx    <= '0;
            last_idx  <= '0;
            chk       <= '0;
            idle_cnt  <= '0;
            m_tdata   <= '0;
            m_tvalid  <= 1'b0;
            m_tlast   <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_count <= '0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;

            if (in_frame) begin
                idle_cnt <= accept ? '0 : idle_cnt + 1'b1;
            end else begin
                idle_cnt <= '0;
            end

            if (timeout_hit) begin
                state     <= IDLE;
                idle_cnt  <= '0;
                frame_err <= 1'b1;
                err_count <= err_next;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept && s_tdata == SOF) begin
                            state <= LEN;
                        end
                    end
                    LEN: begin
                        if (accept) begin
                            if (s_tdata == '0 || s_tdata > MAX_LEN_W) begin
                                state     <= IDLE;
                                frame_err <= 1'b1;
                                err_count <= err_next;
                            end else begin
                                last_idx <= IW'(s_tdata - 1'b1);
                                chk      <= s_tdata;
                                wr_idx   <= '0;
                                state    <= PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (accept) begin
                            chk    <= chk ^ s_tdata;
                            wr_idx <= wr_idx + 1'b1;
                            if (wr_idx == last_idx) begin
                                state <= CHK;
                            end
                        end
                    end
                    CHK: begin
                        // A byte equal to SOF here is still just a checksum.
                        if (accept) begin
                            if (s_tdata == chk) begin
                                frame_ok <= 1'b1;
                                state    <= DRAIN;
                                rd_idx   <= '0;
                                m_tvalid <= 1'b1;
                                m_tdata  <= buffer[0];
                                m_tlast  <= (last_idx == '0);
                            end else begin
                                state     <= IDLE;
                                frame_err <= 1'b1;
                                err_count <= err_next;
                            end
                        end
                    end
                    DRAIN: begin
                        if (m_tvalid && m_tready) begin
                            if (m_tlast) begin
                                m_tvalid <= 1'b0;
                                m_tlast  <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                rd_idx  <= rd_next;
                                m_tdata <= buffer[rd_next];
                                m_tlast <= (rd_next == last_idx);
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx
// Randomised and directed stimulus for uart_frame_rx. A stream-level
// reference model predicts frame outcomes and payload beats into queues;
// an independent monitor pops and compares whenever the DUT emits a pulse
// or an output beat.
module tb_uart_frame_rx;

    localparam int         DW   = 8;
    localparam int         ML   = 16;
    localparam int         TO   = 1024;
    localparam logic [7:0] SOFB = 8'hA5;

    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic          frame_ok;
    logic          frame_err;
    logic [7:0]    err_count;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] beat_q[$];
    int         pulse_q[$];
    int         model_errs = 0;
    int         tready_mode = 0;

    uart_frame_rx #(
        .DATA_WIDTH(DW),
        .MAX_LEN   (ML),
        .SOF       (SOFB),
        .TIMEOUT   (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast),
        .frame_ok (frame_ok),
        .frame_err(frame_err),
        .err_count(err_count)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Single comparison point; every check in the bench goes through here
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Stream-level reference: walk the byte stream, skip non-SOF bytes,
    // judge each frame by its length and XOR checksum, and record the
    // outcome plus any payload that must appear downstream.
    function automatic void predict(input bq_t q);
        int         i;
        int         len;
        logic [7:0] x;
        i = 0;
        while (i < q.size()) begin
            if (q[i] != SOFB) begin
                i++;
                continue;
            end
            if (i + 1 >= q.size()) break;
            len = int'(q[i+1]);
            if (len == 0 || len > ML) begin
                pulse_q.push_back(0);
                i += 2;
                continue;
            end
            if (i + 2 + len >= q.size()) break;
            x = q[i+1];
            for (int k = 0; k < len; k++) x = x ^ q[i+2+k];
            if (q[i+2+len] == x) begin
                pulse_q.push_back(1);
                for (int k = 0; k < len; k++) beat_q.push_back({(k == len - 1), q[i+2+k]});
            end else begin
                pulse_q.push_back(0);
            end
            i += len + 3;
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one byte and hold it until the DUT takes it
    task automatic applyStimulus(input logic [7:0] b);
        int waited;
        waited   = 0;
        s_tdata  = b;
        s_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            waited++;
            if (waited > 2000) begin
                checkOutput("s_tready_wait", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic sendBytes(input bq_t q, input int gapmax);
        foreach (q[i]) begin
            applyStimulus(q[i]);
            if (gapmax > 0) idle($urandom_range(0, gapmax));
        end
    endtask

    task automatic waitEmpty(input int budget);
        int n;
        n = 0;
        while ((beat_q.size() != 0 || pulse_q.size() != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= budget) checkOutput("drain_budget", beat_q.size() + pulse_q.size(), 0);
        idle(3);
    endtask

    function automatic bq_t makeGood(input int len);
        bq_t        q;
        logic [7:0] x;
        logic [7:0] b;
        x = 8'(len);
        q.push_back(SOFB);
        q.push_back(8'(len));
        for (int k = 0; k < len; k++) begin
            b = 8'($urandom);
            x = x ^ b;
            q.push_back(b);
        end
        q.push_back(x);
        return q;
    endfunction

    function automatic logic [7:0] garbageByte();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == SOFB) b = 8'h00;
        return b;
    endfunction

    // Downstream ready pattern: 0 always ready, 1 toggle, 2 random, 3 manual
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (tready_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = ~m_tready;
                2:       m_tready = 1'($urandom);
                default: m_tready = m_tready;
            endcase
        end
    end

    // Monitor: pops expectations whenever the DUT emits a pulse or a beat,
    // and enforces output stability while stalled.
    initial begin
        bit         prev_stall;
        logic [8:0] prev_beat;
        int         exp;
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                continue;
            end
            if (frame_ok || frame_err) begin
                checkOutput("ok_err_exclusive", longint'(frame_ok && frame_err), 0);
                if (pulse_q.size() == 0) begin
                    checkOutput("unexpected_pulse_ok", longint'(frame_ok), 0);
                end else begin
                    exp = pulse_q.pop_front();
                    checkOutput("pulse_kind_ok", longint'(frame_ok), exp);
                    if (exp == 0 && model_errs < 255) model_errs++;
                    checkOutput("err_count", err_count, model_errs);
                end
            end
            if (prev_stall) begin
                checkOutput("hold_valid", m_tvalid, 1);
                checkOutput("hold_beat", {m_tlast, m_tdata}, prev_beat);
            end
            if (m_tvalid) checkOutput("s_tready_in_drain", s_tready, 0);
            if (m_tvalid && m_tready) begin
                if (beat_q.size() == 0) checkOutput("unexpected_beat", 1, 0);
                else checkOutput("beat", {m_tlast, m_tdata}, beat_q.pop_front());
            end
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = {m_tlast, m_tdata};
        end
    end

    // Main sequence: reset, directed scenarios, random traffic, reset
    // during drain, then error-counter saturation.
    initial begin
        bq_t q;
        int  kind;
        int  len;
        int  n;

        rst      = 1'b1;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        idle(3);
        rst = 1'b0;
        checkOutput("reset_s_tready", s_tready, 1);
        checkOutput("reset_m_tvalid", m_tvalid, 0);
        checkOutput("reset_m_tlast", m_tlast, 0);
        checkOutput("reset_m_tdata", m_tdata, 0);
        checkOutput("reset_frame_ok", frame_ok, 0);
        checkOutput("reset_frame_err", frame_err, 0);
        checkOutput("reset_err_count", err_count, 0);

        $display("[TB] good frame");
        q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        predict(q);
        sendBytes(q, 0);
        waitEmpty(200);
        checkOutput("good_err_count", err_count, 0);

        $display("[TB] bad checksum then good single-byte frame");
        q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31, 8'hA5, 8'h01, 8'h7F, 8'h7E};
        predict(q);
        sendBytes(q, 0);
        waitEmpty(200);
        checkOutput("badchk_err_count", err_count, 1);

        $display("[TB] garbage and bad lengths");
        q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'hA5, 8'h11};
        predict(q);
        sendBytes(q, 0);
        waitEmpty(200);
        checkOutput("len_err_count", err_count, 3);

        $display("[TB] backpressure toggling");
        tready_mode = 1;
        q = makeGood(3);
        predict(q);
        sendBytes(q, 0);
        waitEmpty(200);
        tready_mode = 0;

        $display("[TB] timeout");
        pulse_q.push_back(0);
        sendBytes('{8'hA5, 8'h02, 8'h11}, 0);
        for (int c = 0; c < TO; c++) begin
            @(negedge clk);
            if (c == 0 || c == TO - 1) checkOutput("stall_s_tready", s_tready, 1);
            @(posedge clk);
            #1;
        end
        checkOutput("no_early_timeout", frame_err, 0);
        s_tdata  = SOFB;
        s_tvalid = 1'b1;
        @(negedge clk);
        checkOutput("timeout_cycle_ready", s_tready, 1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        checkOutput("timeout_pulse", frame_err, 1);
        q = '{8'h01, 8'h7F, 8'h7E};
        predict(q);
        sendBytes(q, 0);
        q = makeGood(4);
        predict(q);
        sendBytes(q, 0);
        waitEmpty(200);

        $display("[TB] random traffic");
        for (int f = 0; f < 50; f++) begin
            tready_mode = $urandom_range(0, 2);
            q = {};
            n = $urandom_range(0, 2);
            for (int g = 0; g < n; g++) q.push_back(garbageByte());
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, ML);
            if (kind <= 4) begin
                q = {q, makeGood(len)};
            end else if (kind <= 6) begin
                q = {q, makeGood(len)};
                q[q.size()-1] = q[q.size()-1] ^ 8'($urandom_range(1, 255));
            end else if (kind == 7) begin
                q.push_back(SOFB);
                q.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(ML + 1, 255)));
            end else if (kind == 8) begin
                q.push_back(SOFB);
                if ($urandom_range(0, 3) != 0) begin
                    q.push_back(8'(len));
                    n = $urandom_range(0, len - 1);
                    for (int k = 0; k < n; k++) q.push_back(8'($urandom));
                end
            end
            predict(q);
            if (kind == 8) pulse_q.push_back(0);
            sendBytes(q, 2);
            if (kind == 8) idle(TO + 2);
        end
        tready_mode = 0;
        waitEmpty(2000);

        $display("[TB] reset during drain");
        tready_mode = 3;
        m_tready    = 1'b0;
        idle(1);
        q = makeGood(3);
        predict(q);
        sendBytes(q, 0);
        n = 0;
        while (!m_tvalid && n < 50) begin
            idle(1);
            n++;
        end
        checkOutput("drain_started", m_tvalid, 1);
        m_tready = 1'b1;
        idle(1);
        m_tready = 1'b0;
        rst      = 1'b1;
        idle(1);
        rst = 1'b0;
        beat_q.delete();
        model_errs = 0;
        checkOutput("rst_drain_m_tvalid", m_tvalid, 0);
        checkOutput("rst_drain_m_tlast", m_tlast, 0);
        checkOutput("rst_drain_m_tdata", m_tdata, 0);
        checkOutput("rst_drain_s_tready", s_tready, 1);
        checkOutput("rst_drain_err_count", err_count, 0);
        tready_mode = 0;
        idle(20);
        checkOutput("rst_drain_pulses_left", pulse_q.size(), 0);

        $display("[TB] error counter saturation");
        for (int f = 0; f < 300; f++) begin
            q = '{8'hA5, 8'h00};
            predict(q);
            sendBytes(q, 0);
        end
        waitEmpty(200);
        checkOutput("sat_err_count", err_count, 255);
        checkOutput("queues_empty", beat_q.size() + pulse_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
